// File: rtl/rib_timer_pkg.sv
// Shared RIB bus types, timer register offsets, CTRL bit positions and slot base.
// Used by the timer whether or not RIB_TIMER_PRESCALER_EN is defined.
package rib_timer_pkg;

    localparam int MEM_BUS_W = 32;

    typedef logic [MEM_BUS_W-1:0] mem_bus_t;
    typedef logic [MEM_BUS_W-1:0] mem_addr_bus_t;

    localparam mem_bus_t      ZeroWord     = '0;
    localparam logic          WriteEnable  = 1'b1;
    localparam logic          WriteDisable = 1'b0;
    localparam mem_addr_bus_t SLAVE4_BASE  = 32'h4000_0000;

    localparam logic [7:0] TIMER_CTRL     = 8'h00;
    localparam logic [7:0] TIMER_COUNT    = 8'h04;
    localparam logic [7:0] TIMER_COMPARE  = 8'h08;
    localparam logic [7:0] TIMER_PRESCALE = 8'h0C;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_IE       = 1;
    localparam int CTRL_PERIODIC = 2;
    localparam int CTRL_PEND     = 3;

    function automatic mem_bus_t ctrl_word(input logic en, input logic ie,
                                           input logic periodic, input logic pend);
        mem_bus_t w;
        w                = ZeroWord;
        w[CTRL_EN]       = en;
        w[CTRL_IE]       = ie;
        w[CTRL_PERIODIC] = periodic;
        w[CTRL_PEND]     = pend;
        return w;
    endfunction

endpackage

// File: rtl/rib_timer_if.sv
// RIB slave-slot bus bundle: slot-local address, write data/enable and combinational read data.
interface rib_timer_if;
    import rib_timer_pkg::*;

    mem_addr_bus_t addr_i;
    mem_bus_t      data_i;
    logic          we_i;
    mem_bus_t      data_o;

    modport master (output addr_i, output data_i, output we_i, input data_o);
    modport slave  (input addr_i, input data_i, input we_i, output data_o);

endinterface

// File: rtl/rib_timer_prescaler.sv
// Prescale counter producing a one-cycle tick every load+1 enabled cycles.
// Only compiled when RIB_TIMER_PRESCALER_EN is defined.
`ifdef RIB_TIMER_PRESCALER_EN
module rib_timer_prescaler #(
    parameter int PRE_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [PRE_W-1:0] load,
    output logic             tick
);

    logic [PRE_W-1:0] cnt_q;
    logic [PRE_W-1:0] cnt_d;

    assign tick = en && (cnt_q == load);

    // Restart the count on disable, on a new load value, and after each tick.
    always_comb begin
        cnt_d = cnt_q + PRE_W'(1);
        if (!en || clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/rib_timer.sv
// RIB slave-4 timer: register file, prescaled counter with compare match and level interrupt.
// Define RIB_TIMER_PRESCALER_EN to add the PRESCALE register and prescale counter.
module rib_timer
    import rib_timer_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int PRE_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    rib_timer_if.slave bus,
    output logic       int_sig_o
);

    logic [7:0]       offset;
    logic             unused_addr_bits;
    logic             wr_ctrl;
    logic             wr_count;
    logic             wr_compare;
    logic             tick_raw;
    logic             tick;
    logic [PRE_W-1:0] prescale_word;

    logic             en_q, en_d;
    logic             ie_q, ie_d;
    logic             periodic_q, periodic_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] compare_q, compare_d;

    assign offset           = bus.addr_i[7:0];
    assign unused_addr_bits = ^bus.addr_i[31:8];

    assign wr_ctrl    = (bus.we_i == WriteEnable) && (offset == TIMER_CTRL);
    assign wr_count   = (bus.we_i == WriteEnable) && (offset == TIMER_COUNT);
    assign wr_compare = (bus.we_i == WriteEnable) && (offset == TIMER_COMPARE);

`ifdef RIB_TIMER_PRESCALER_EN
    logic             wr_prescale;
    logic [PRE_W-1:0] prescale_q, prescale_d;

    assign wr_prescale = (bus.we_i == WriteEnable) && (offset == TIMER_PRESCALE);

    always_comb begin
        prescale_d = prescale_q;
        if (wr_prescale) begin
            prescale_d = bus.data_i[PRE_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prescale_q <= '0;
        end else begin
            prescale_q <= prescale_d;
        end
    end

    rib_timer_prescaler #(
        .PRE_W (PRE_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (en_q),
        .clr  (wr_prescale),
        .load (prescale_q),
        .tick (tick_raw)
    );

    assign prescale_word = prescale_q;
`else
    assign tick_raw      = en_q;
    assign prescale_word = '0;
`endif

    // A software write clearing EN swallows a tick landing in the same cycle.
    assign tick = tick_raw && !(wr_ctrl && !bus.data_i[CTRL_EN]);

    // Match uses pre-write COUNT/COMPARE; a hardware PEND set beats a same-cycle W1C,
    // and a software COUNT write beats the increment.
    always_comb begin
        en_d       = en_q;
        ie_d       = ie_q;
        periodic_d = periodic_q;
        pend_d     = pend_q;
        count_d    = count_q;
        compare_d  = compare_q;

        if (wr_ctrl) begin
            en_d       = bus.data_i[CTRL_EN];
            ie_d       = bus.data_i[CTRL_IE];
            periodic_d = bus.data_i[CTRL_PERIODIC];
            if (bus.data_i[CTRL_PEND]) begin
                pend_d = 1'b0;
            end
        end

        if (tick) begin
            if (count_q == compare_q) begin
                pend_d = 1'b1;
                if (periodic_q) begin
                    count_d = '0;
                end else begin
                    en_d = 1'b0;
                end
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end

        if (wr_count) begin
            count_d = bus.data_i[CNT_W-1:0];
        end
        if (wr_compare) begin
            compare_d = bus.data_i[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q       <= 1'b0;
            ie_q       <= 1'b0;
            periodic_q <= 1'b0;
            pend_q     <= 1'b0;
            count_q    <= '0;
            compare_q  <= '0;
        end else begin
            en_q       <= en_d;
            ie_q       <= ie_d;
            periodic_q <= periodic_d;
            pend_q     <= pend_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
        end
    end

    always_comb begin
        bus.data_o = ZeroWord;
        case (offset)
            TIMER_CTRL:     bus.data_o = ctrl_word(en_q, ie_q, periodic_q, pend_q);
            TIMER_COUNT:    bus.data_o = mem_bus_t'(count_q);
            TIMER_COMPARE:  bus.data_o = mem_bus_t'(compare_q);
            TIMER_PRESCALE: bus.data_o = mem_bus_t'(prescale_word);
            default:        bus.data_o = ZeroWord;
        endcase
    end

    assign int_sig_o = pend_q & ie_q;

endmodule
